step_burst_controller: RTL and testbench
========================================

STEP_BURST_CONTROLLER -- requirements
Module: step_burst_controller

Interface
REQ-001 Parameter CNT_W, default 16: width of the burst-length counter and of the run_len and remaining ports.
REQ-002 Parameter FULL_LEN, default 50: default burst length in clocks when step=1 (full step).
REQ-003 Parameter HALF_LEN, default 100: default burst length in clocks when step=0 (half step).
REQ-004 Port new_clk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port press, input, 1 bit: burst request; a single-cycle pulse that has already been debounced and synchronised.
REQ-007 Port step, input, 1 bit: mode select; 1 = full step, 0 = half step.
REQ-008 Port dir_in, input, 1 bit: requested motor direction.
REQ-009 Port run_len, input, CNT_W bits: explicit burst length; 0 selects the default for the current step mode.
REQ-010 Port abort, input, 1 bit: synchronous stop request.
REQ-011 Port out_to_sm, output, 1 bit: enable to the stepper sequencer; high for the duration of a burst.
REQ-012 Port dir_out, output, 1 bit: direction of the active burst.
REQ-013 Port busy, output, 1 bit: high when the state is RUN or GAP.
REQ-014 Port done, output, 1 bit: single-cycle pulse at the normal completion of a burst.
REQ-015 Port overrun, output, 1 bit: single-cycle pulse when a request is dropped.
REQ-016 Port remaining, output, CNT_W bits: number of enabled cycles left in the current burst, counting the current cycle.

Function
REQ-017 The controller SHALL use three states, IDLE, RUN and GAP, with all outputs registered.
REQ-018 Burst length SHALL be L = run_len when run_len is nonzero, otherwise FULL_LEN when step=1 and HALF_LEN when step=0; step, dir_in and run_len SHALL be sampled in the same cycle that press is sampled.
REQ-019 When press=1 in IDLE, the next edge SHALL enter RUN with out_to_sm=1, remaining=L and dir_out=dir_in.
REQ-020 In RUN, out_to_sm SHALL remain high for exactly L consecutive cycles, with remaining decrementing by 1 each edge.
REQ-021 On the edge where remaining=1 in RUN, the block SHALL drop out_to_sm, set remaining=0 and pulse done for 1 cycle.
REQ-022 On that same edge, the next state SHALL be GAP if a request is pending, otherwise IDLE.
REQ-023 GAP SHALL last exactly 1 cycle with out_to_sm=0; it SHALL then enter RUN loaded from the pending request, and the pending flag SHALL clear.
REQ-024 When press=1 in RUN or GAP with no request pending, the block SHALL capture L and dir_in into a single-entry pending slot.
REQ-025 When press=1 while a request is already pending, the new request SHALL be dropped and overrun SHALL pulse; the existing pending request SHALL be kept.
REQ-026 A press arriving on the completion edge SHALL be treated as pending and SHALL follow REQ-024 and REQ-025.
REQ-027 dir_out SHALL be stable for the whole burst and SHALL change only on entry to RUN.
REQ-028 When abort=1 in any state, the next edge SHALL force IDLE, out_to_sm=0, remaining=0 and clear the pending slot; done SHALL NOT pulse.
REQ-029 When abort=1 and press=1 in the same cycle, abort SHALL win; the press SHALL be dropped without an overrun pulse.
REQ-030 Arithmetic SHALL be unsigned CNT_W bits; remaining SHALL never wrap below 0.
REQ-031 Elaboration SHALL fail if FULL_LEN or HALF_LEN is 0 or does not fit in CNT_W bits.
REQ-032 Every output SHALL be driven from a register.

Reset
REQ-033 While rst=0, the block SHALL hold IDLE, out_to_sm=0, dir_out=0, busy=0, done=0, overrun=0, remaining=0 and the pending slot empty.
REQ-034 Reset asserted mid-burst SHALL drop out_to_sm immediately, asynchronously, without a done pulse.
REQ-035 After rst deasserts, the first press SHALL be honoured per REQ-019.

Verification
REQ-036 Scenario: step=1, run_len=0, one press -> out_to_sm high exactly 50 cycles, remaining counts 50..1, done pulses once, busy low afterwards.
REQ-037 Scenario: step=0, run_len=0 -> 100-cycle burst; then run_len=3 -> 3-cycle burst.
REQ-038 Scenario: during a burst, press with dir_in=1 then press again -> second request queued and third press gives an overrun pulse; first burst ends, one GAP cycle with out_to_sm=0, then a queued burst with dir_out=1.
REQ-039 Scenario: abort at cycle 10 of a 50-cycle burst with a pending request -> out_to_sm low next edge, no done, no queued burst runs.
REQ-040 Scenario: abort and press in the same cycle while in IDLE -> remains IDLE, no overrun.
REQ-041 Scenario: rst pulsed low mid-burst -> all outputs 0 immediately; a fresh press after release gives a full burst.

Source files
------------

// File: rtl/step_burst_controller.sv
// Stepper burst controller: turns a press pulse into a fixed-length enable burst,
// with a one-entry pending slot, a one-cycle gap between queued bursts, and abort.
module step_burst_controller #(
    parameter int CNT_W    = 16,
    parameter int FULL_LEN = 50,
    parameter int HALF_LEN = 100
) (
    input  logic             new_clk,
    input  logic             rst,
    input  logic             press,
    input  logic             step,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] run_len,
    input  logic             abort,
    output logic             out_to_sm,
    output logic             dir_out,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [CNT_W-1:0] remaining
);

    generate
        if (FULL_LEN <= 0 || HALF_LEN <= 0 ||
            (FULL_LEN >> CNT_W) != 0 || (HALF_LEN >> CNT_W) != 0) begin : g_bad_len
            $error("step_burst_controller: FULL_LEN/HALF_LEN must be nonzero and fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] FULL_L = CNT_W'(FULL_LEN);
    localparam logic [CNT_W-1:0] HALF_L = CNT_W'(HALF_LEN);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pend_valid;
    logic             pend_dir;
    logic [CNT_W-1:0] pend_len;

    logic             out_nxt;
    logic             dir_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             overrun_nxt;
    logic [CNT_W-1:0] remaining_nxt;
    logic             pend_valid_nxt;
    logic             pend_dir_nxt;
    logic [CNT_W-1:0] pend_len_nxt;

    logic [CNT_W-1:0] req_len;
    logic             last_cycle;

    assign req_len    = (run_len != '0) ? run_len : (step ? FULL_L : HALF_L);
    // Treating 0 as a last cycle keeps remaining from ever wrapping.
    assign last_cycle = (remaining <= ONE);

    always_ff @(posedge new_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            out_to_sm  <= 1'b0;
            dir_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            remaining  <= '0;
            pend_valid <= 1'b0;
            pend_dir   <= 1'b0;
            pend_len   <= '0;
        end else begin
            state      <= state_nxt;
            out_to_sm  <= out_nxt;
            dir_out    <= dir_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            overrun    <= overrun_nxt;
            remaining  <= remaining_nxt;
            pend_valid <= pend_valid_nxt;
            pend_dir   <= pend_dir_nxt;
            pend_len   <= pend_len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (press) state_nxt = RUN;
                RUN:     if (last_cycle) state_nxt = (pend_valid || press) ? GAP : IDLE;
                GAP:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_nxt        = out_to_sm;
        dir_nxt        = dir_out;
        done_nxt       = 1'b0;
        overrun_nxt    = 1'b0;
        remaining_nxt  = remaining;
        pend_valid_nxt = pend_valid;
        pend_dir_nxt   = pend_dir;
        pend_len_nxt   = pend_len;
        busy_nxt       = (state_nxt != IDLE);

        if (abort) begin
            out_nxt        = 1'b0;
            remaining_nxt  = '0;
            pend_valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        out_nxt       = 1'b1;
                        remaining_nxt = req_len;
                        dir_nxt       = dir_in;
                    end
                end
                RUN: begin
                    if (press) begin
                        if (pend_valid) begin
                            overrun_nxt = 1'b1;
                        end else begin
                            pend_valid_nxt = 1'b1;
                            pend_len_nxt   = req_len;
                            pend_dir_nxt   = dir_in;
                        end
                    end
                    if (last_cycle) begin
                        out_nxt       = 1'b0;
                        remaining_nxt = '0;
                        done_nxt      = 1'b1;
                    end else begin
                        remaining_nxt = remaining - ONE;
                    end
                end
                GAP: begin
                    // The slot is still occupied while GAP is sampled, so a press here overruns.
                    if (press) overrun_nxt = 1'b1;
                    out_nxt        = 1'b1;
                    remaining_nxt  = pend_len;
                    dir_nxt        = pend_dir;
                    pend_valid_nxt = 1'b0;
                end
                default: begin
                    out_nxt       = 1'b0;
                    remaining_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_burst_controller.sv
// Scoreboard bench for step_burst_controller: a transaction-level burst model
// predicts every cycle's outputs, and a monitor compares them after each edge.
module tb_step_burst_controller;

    localparam int CNT_W    = 16;
    localparam int FULL_LEN = 50;
    localparam int HALF_LEN = 100;

    typedef struct packed {
        logic             out;
        logic             dir;
        logic             busy;
        logic             done;
        logic             overrun;
        logic [CNT_W-1:0] rem;
    } out_t;

    typedef struct {
        int len;
        bit dir;
    } burst_t;

    logic             new_clk;
    logic             rst;
    logic             press;
    logic             step;
    logic             dir_in;
    logic [CNT_W-1:0] run_len;
    logic             abort;
    logic             out_to_sm;
    logic             dir_out;
    logic             busy;
    logic             done;
    logic             overrun;
    logic [CNT_W-1:0] remaining;

    int checks_total  = 0;
    int checks_passed = 0;

    out_t   exp_q[$];
    burst_t pend[$];
    int     cur_left = 0;
    bit     in_gap   = 1'b0;
    bit     m_dir    = 1'b0;

    step_burst_controller #(
        .CNT_W   (CNT_W),
        .FULL_LEN(FULL_LEN),
        .HALF_LEN(HALF_LEN)
    ) dut (
        .new_clk  (new_clk),
        .rst      (rst),
        .press    (press),
        .step     (step),
        .dir_in   (dir_in),
        .run_len  (run_len),
        .abort    (abort),
        .out_to_sm(out_to_sm),
        .dir_out  (dir_out),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun),
        .remaining(remaining)
    );

    initial begin
        new_clk = 1'b0;
        forever #5 new_clk = ~new_clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = '{out_to_sm, dir_out, busy, done, overrun, remaining};
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s @%0t: got out=%0b dir=%0b busy=%0b done=%0b ovr=%0b rem=%0d, expected out=%0b dir=%0b busy=%0b done=%0b ovr=%0b rem=%0d",
                     name, $time, act.out, act.dir, act.busy, act.done, act.overrun, act.rem,
                     exp.out, exp.dir, exp.busy, exp.done, exp.overrun, exp.rem);
        end
    endtask

    // One clock of the reference behaviour: bursts are just a countdown plus a one-deep queue.
    task automatic modelStep(input bit p, input bit s, input bit d, input int len, input bit a,
                             output out_t exp);
        int     l;
        bit     was_busy;
        bit     dn;
        bit     ov;
        burst_t b;
        dn = 1'b0;
        ov = 1'b0;
        l  = (len != 0) ? len : (s ? FULL_LEN : HALF_LEN);
        if (a) begin
            cur_left = 0;
            in_gap   = 1'b0;
            pend.delete();
        end else begin
            was_busy = (cur_left > 0) || in_gap;
            if (p && was_busy) begin
                if (pend.size() != 0) ov = 1'b1;
                else begin
                    b.len = l;
                    b.dir = d;
                    pend.push_back(b);
                end
            end
            if (in_gap) begin
                b        = pend.pop_front();
                cur_left = b.len;
                m_dir    = b.dir;
                in_gap   = 1'b0;
            end else if (cur_left > 0) begin
                cur_left--;
                if (cur_left == 0) begin
                    dn = 1'b1;
                    if (pend.size() != 0) in_gap = 1'b1;
                end
            end else if (p) begin
                cur_left = l;
                m_dir    = d;
            end
        end
        exp.out     = (cur_left > 0);
        exp.dir     = m_dir;
        exp.busy    = (cur_left > 0) || in_gap;
        exp.done    = dn;
        exp.overrun = ov;
        exp.rem     = CNT_W'(cur_left);
    endtask

    task automatic applyStimulus(input bit p, input bit s, input bit d, input int len, input bit a);
        out_t exp;
        @(posedge new_clk);
        #2;
        press   = p;
        step    = s;
        dir_in  = d;
        run_len = CNT_W'(len);
        abort   = a;
        modelStep(p, s, d, len, a, exp);
        exp_q.push_back(exp);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic doReset();
        out_t zero;
        zero = '0;
        @(posedge new_clk);
        #4;
        rst = 1'b0;
        cur_left = 0;
        in_gap   = 1'b0;
        m_dir    = 1'b0;
        pend.delete();
        #1;
        checkOutput("async_reset", zero);
        @(posedge new_clk);
        #1;
        checkOutput("reset_hold", zero);
        #2;
        rst = 1'b1;
    endtask

    // Monitor: every edge that follows a driven cycle has one prediction waiting.
    initial begin
        out_t e;
        forever begin
            @(posedge new_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("cycle", e);
            end
        end
    end

    initial begin
        out_t zero;
        zero    = '0;
        rst     = 1'b1;
        press   = 1'b0;
        step    = 1'b0;
        dir_in  = 1'b0;
        run_len = '0;
        abort   = 1'b0;
        #1 rst = 1'b0;
        #11;
        checkOutput("power_on_reset", zero);
        #1 rst = 1'b1;

        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
        idleCycles(55);

        applyStimulus(1'b1, 1'b0, 1'b1, 0, 1'b0);
        idleCycles(105);
        applyStimulus(1'b1, 1'b0, 1'b0, 3, 1'b0);
        idleCycles(5);

        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
        idleCycles(5);
        applyStimulus(1'b1, 1'b1, 1'b1, 4, 1'b0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 7, 1'b0);
        idleCycles(60);

        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b0);
        idleCycles(5);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        idleCycles(55);

        applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b1);
        idleCycles(3);

        applyStimulus(1'b1, 1'b0, 1'b0, 3, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b1, 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 9, 1'b0);
        idleCycles(6);

        applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b0);
        idleCycles(10);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
        idleCycles(55);

        for (int i = 0; i < 3000; i++) begin
            bit p, s, d, a;
            int len;
            p   = ($urandom_range(0, 5) == 0);
            a   = ($urandom_range(0, 63) == 0);
            s   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12));
            applyStimulus(p, s, d, len, a);
        end
        idleCycles(110);

        @(posedge new_clk);
        #3;
        checks_total++;
        if (exp_q.size() == 0) checks_passed++;
        else $display("[TB] FAIL scoreboard_drain: got %0d predictions left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
